// File: rtl/y86_pkg.sv
// Shared Y86-64 instruction codes and register-ID constants for the decode /
// write-back register file slice.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // "No register" ID for the default 4-bit register-ID width.
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam int RSP_ID_DEFAULT = 4;

endpackage

// File: rtl/y86_src_dst_sel.sv
// Combinational Y86-64 source/destination register selection from
// icode, cnd and the rA/rB instruction fields.
module y86_src_dst_sel
    import y86_pkg::*;
#(
    parameter int RID_W  = 4,
    parameter int RSP_ID = RSP_ID_DEFAULT
) (
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [RID_W-1:0] rA,
    input  logic [RID_W-1:0] rB,
    output logic [RID_W-1:0] srcA,
    output logic [RID_W-1:0] srcB,
    output logic [RID_W-1:0] dstE,
    output logic [RID_W-1:0] dstM
);

    localparam logic [RID_W-1:0] NONE = '1;
    localparam logic [RID_W-1:0] RSP  = RID_W'(RSP_ID);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        srcA = NONE;
        srcB = NONE;
        dstE = NONE;
        dstM = NONE;
        case (icode)
            I_CMOVXX: begin
                srcA = rA;
                if (cnd) dstE = rB;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            I_HALT, I_NOP, I_JXX: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/y86_decode_wb_rf.sv
// Y86-64 decode register file with clocked valE/valM write-back and a
// retired-write counter. Define Y86_RF_BYPASS_EN for same-cycle read bypass.
module y86_decode_wb_rf
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int RID_W  = 4,
    parameter int RSP_ID = RSP_ID_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              icode,
    input  logic                    cnd,
    input  logic [RID_W-1:0]        rA,
    input  logic [RID_W-1:0]        rB,
    input  logic [DATA_W-1:0]       valE,
    input  logic [DATA_W-1:0]       valM,
    input  logic                    wb_en,
    output logic [DATA_W-1:0]       valA,
    output logic [DATA_W-1:0]       valB,
    output logic [RID_W-1:0]        srcA,
    output logic [RID_W-1:0]        srcB,
    output logic [RID_W-1:0]        dstE,
    output logic [RID_W-1:0]        dstM,
    output logic                    vflag,
    output logic [CNT_W-1:0]        wb_count,
    output logic [NREGS*DATA_W-1:0] rf_flat
);

    localparam int               IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [RID_W-1:0] NREGS_ID = RID_W'(NREGS);

    logic [DATA_W-1:0] rf [NREGS];
    logic              src_a_ok, src_b_ok, dst_e_ok, dst_m_ok;
    logic [DATA_W-1:0] stored_a, stored_b;

    y86_src_dst_sel #(
        .RID_W  (RID_W),
        .RSP_ID (RSP_ID)
    ) u_sel (
        .icode (icode),
        .cnd   (cnd),
        .rA    (rA),
        .rB    (rB),
        .srcA  (srcA),
        .srcB  (srcB),
        .dstE  (dstE),
        .dstM  (dstM)
    );

    assign src_a_ok = (srcA < NREGS_ID);
    assign src_b_ok = (srcB < NREGS_ID);
    assign dst_e_ok = (dstE < NREGS_ID);
    assign dst_m_ok = (dstM < NREGS_ID);
    assign vflag    = src_a_ok && src_b_ok;

    assign stored_a = src_a_ok ? rf[IDX_W'(srcA)] : '0;
    assign stored_b = src_b_ok ? rf[IDX_W'(srcB)] : '0;

`ifdef Y86_RF_BYPASS_EN
    // valM is checked first so a popq %rsp read sees the same value that commits.
    always_comb begin
        valA = stored_a;
        valB = stored_b;
        if (wb_en) begin
            if (dst_m_ok && srcA == dstM)      valA = valM;
            else if (dst_e_ok && srcA == dstE) valA = valE;
            if (dst_m_ok && srcB == dstM)      valB = valM;
            else if (dst_e_ok && srcB == dstE) valB = valE;
        end
    end
`else
    assign valA = stored_a;
    assign valB = stored_b;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register file is reset on purpose: software relies on register i holding i.
            for (int i = 0; i < NREGS; i++) rf[IDX_W'(i)] <= DATA_W'(i);
            wb_count <= '0;
        end else if (wb_en) begin
            if (dst_e_ok) rf[IDX_W'(dstE)] <= valE;
            // NOTE: with non-blocking updates the last assignment in the block wins, so valM beats valE on dstE == dstM.
            if (dst_m_ok) rf[IDX_W'(dstM)] <= valM;
            if (dst_e_ok || dst_m_ok) wb_count <= wb_count + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign rf_flat[g*DATA_W +: DATA_W] = rf[g];
    end

endmodule

// File: tb/tb_y86_decode_wb_rf.sv
// Self-checking bench for y86_decode_wb_rf: directed scenarios then random
// instructions compared against an array-based model of the register file.
module tb_y86_decode_wb_rf;
    import y86_pkg::*;

    localparam int DW = 64;
    localparam int NR = 15;
    localparam int RW = 4;
    localparam int CW = 2;

    logic           clk;
    logic           rst_n;
    logic [3:0]     icode;
    logic           cnd;
    logic [RW-1:0]  rA, rB;
    logic [DW-1:0]  valE, valM;
    logic           wb_en;
    logic [DW-1:0]  valA, valB;
    logic [RW-1:0]  srcA, srcB, dstE, dstM;
    logic           vflag;
    logic [CW-1:0]  wb_count;
    logic [NR*DW-1:0] rf_flat;

    y86_decode_wb_rf #(
        .DATA_W (DW),
        .NREGS  (NR),
        .RID_W  (RW),
        .RSP_ID (4),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .icode    (icode),
        .cnd      (cnd),
        .rA       (rA),
        .rB       (rB),
        .valE     (valE),
        .valM     (valM),
        .wb_en    (wb_en),
        .valA     (valA),
        .valB     (valB),
        .srcA     (srcA),
        .srcB     (srcB),
        .dstE     (dstE),
        .dstM     (dstM),
        .vflag    (vflag),
        .wb_count (wb_count),
        .rf_flat  (rf_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint unsigned m_rf [NR];
    int              m_cnt;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_reg(input logic [3:0] id);
        return id < NR;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_rf[i] = longint'(i);
        m_cnt = 0;
    endtask

    // Apply one instruction, check the combinational view, then clock it.
    task automatic apply(input logic [3:0] ic, input logic c, input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] e, input logic [63:0] m, input logic we, input logic rst);
        logic [3:0]  es_a, es_b, ed_e, ed_m;
        logic [63:0] ea, eb;
        icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = m; wb_en = we; rst_n = rst;
        #2;
        es_a = REG_NONE; es_b = REG_NONE; ed_e = REG_NONE; ed_m = REG_NONE;
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) es_a = a;
        if (ic inside {4'hB, 4'h9})             es_a = 4'd4;
        if (ic inside {4'h4, 4'h5, 4'h6})       es_b = b;
        if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) es_b = 4'd4;
        if ((ic == 4'h2 && c) || ic inside {4'h3, 4'h6}) ed_e = b;
        if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) ed_e = 4'd4;
        if (ic inside {4'h5, 4'hB})             ed_m = a;
        ea = is_reg(es_a) ? m_rf[es_a] : 64'd0;
        eb = is_reg(es_b) ? m_rf[es_b] : 64'd0;
`ifdef Y86_RF_BYPASS_EN
        if (we) begin
            if (is_reg(ed_m) && es_a == ed_m)      ea = m;
            else if (is_reg(ed_e) && es_a == ed_e) ea = e;
            if (is_reg(ed_m) && es_b == ed_m)      eb = m;
            else if (is_reg(ed_e) && es_b == ed_e) eb = e;
        end
`endif
        check("srcA", srcA, es_a);
        check("srcB", srcB, es_b);
        check("dstE", dstE, ed_e);
        check("dstM", dstM, ed_m);
        check("valA", valA, ea);
        check("valB", valB, eb);
        check("vflag", vflag, is_reg(es_a) && is_reg(es_b));
        check("wb_count", wb_count, 64'(m_cnt));
        for (int i = 0; i < NR; i++)
            check($sformatf("rf[%0d]", i), rf_flat[i*DW +: DW], m_rf[i]);
        @(posedge clk);
        if (!rst) model_reset();
        else if (we) begin
            if (is_reg(ed_e)) m_rf[ed_e] = e;
            if (is_reg(ed_m)) m_rf[ed_m] = m;
            if (is_reg(ed_e) || is_reg(ed_m)) m_cnt = (m_cnt + 1) % (1 << CW);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; icode = 4'h1; cnd = 1'b0; rA = '0; rB = '0;
        valE = '0; valM = '0; wb_en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, then OPq read of registers 2 and 3.
        apply(I_OPQ, 1'b0, 4'd2, 4'd3, 64'h0, 64'h0, 1'b0, 1'b1);
        apply(I_OPQ, 1'b0, 4'd2, 4'd3, 64'h55, 64'h0, 1'b1, 1'b1);
        apply(I_OPQ, 1'b0, 4'd2, 4'd3, 64'h0, 64'h0, 1'b0, 1'b1);
        // popq into register 4 (the stack pointer): valM wins.
        apply(I_POPQ, 1'b0, 4'd4, 4'hF, 64'h20, 64'h99, 1'b1, 1'b1);
        // cmovxx not taken, then taken.
        apply(I_CMOVXX, 1'b0, 4'd1, 4'd7, 64'h1, 64'h0, 1'b1, 1'b1);
        apply(I_CMOVXX, 1'b1, 4'd1, 4'd7, 64'h1, 64'h0, 1'b1, 1'b1);
        // Reset beats a concurrent write.
        apply(I_OPQ, 1'b0, 4'd2, 4'd5, 64'hFF, 64'h0, 1'b1, 1'b0);
        apply(I_NOP, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0, 1'b0, 1'b1);
        // Counter wrap with a 2-bit counter.
        for (int i = 0; i < 5; i++)
            apply(I_IRMOVQ, 1'b0, 4'hF, 4'(i + 8), 64'(32'hA0 + i), 64'h0, 1'b1, 1'b1);
        // Unknown icode and writes to the NONE register.
        apply(4'hC, 1'b1, 4'd2, 4'd3, 64'h1234, 64'h5678, 1'b1, 1'b1);
        apply(I_OPQ, 1'b0, 4'hF, 4'hF, 64'h77, 64'h0, 1'b1, 1'b1);
        apply(I_MRMOVQ, 1'b0, 4'hF, 4'd2, 64'h0, 64'h66, 1'b1, 1'b1);

        for (int n = 0; n < 300; n++)
            apply(4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), ($urandom_range(0, 24) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_decode_wb_rf.md
Name: y86_decode_wb_rf

Overview:
- Parametrised successor to the SEQ decode stage: register file plus the Y86-64 source/destination selection logic and a clocked write-back port.
- Sits between execute/memory and fetch in the SEQ processor.
- Decode reads are combinational. Write-back of valE/valM commits on the clock edge.
- Register count and data width are generic. Adds a retired-write counter and an optional same-cycle bypass.

Parameters:
- DATA_W, 64, register and data width in bits.
- NREGS, 15, number of architectural registers. Indices NREGS..2^RID_W-1 are treated as "none".
- RID_W, 4, register-ID width. RID_W must satisfy 2^RID_W > NREGS.
- RSP_ID, 4, index of the stack pointer.
- CNT_W, 32, width of the write counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- icode  in  4  instruction code of the current instruction
- cnd  in  1  condition flag from execute; gates the cmovxx write
- rA  in  RID_W  register A field
- rB  in  RID_W  register B field
- valE  in  DATA_W  ALU result to write back
- valM  in  DATA_W  memory result to write back
- wb_en  in  1  write-back strobe, asserted once per instruction
- valA  out  DATA_W  operand A
- valB  out  DATA_W  operand B
- srcA, srcB  out  RID_W  selected source IDs
- dstE, dstM  out  RID_W  selected destination IDs
- vflag  out  1  high when both srcA and srcB are valid registers
- wb_count  out  CNT_W  number of write-back cycles that committed at least one register
- rf_flat  out  NREGS*DATA_W  all registers concatenated, register 0 in the LSBs; debug view

Behaviour:
- Reset:
  - Applied on a clk edge with rst_n=0; reset has priority over any write.
  - Register i takes value i, zero-extended to DATA_W.
  - wb_count clears to 0.
  - Combinational outputs follow the reset register contents.
- srcA (combinational; NONE is all-ones ID):
  - cmovxx(2), rmmovq(4), OPq(6), pushq(A): rA.
  - popq(B), ret(9): RSP_ID.
  - Otherwise NONE.
- srcB:
  - rmmovq, mrmovq(5), OPq: rB.
  - pushq, popq, call(8), ret: RSP_ID.
  - Otherwise NONE.
- dstE:
  - cmovxx: rB if cnd=1, else NONE.
  - irmovq(3), OPq: rB.
  - pushq, popq, call, ret: RSP_ID.
  - Otherwise NONE.
- dstM: mrmovq, popq: rA. Otherwise NONE.
- Reads:
  - valA = rf[srcA] and valB = rf[srcB]; any ID >= NREGS reads as 0.
  - Unknown icode: all IDs NONE, valA = valB = 0, vflag = 0.
  - No latching of previous values.
- Write-back (at the rising edge with rst_n=1 and wb_en=1):
  - rf[dstE] <= valE if dstE < NREGS.
  - rf[dstM] <= valM if dstM < NREGS.
  - If dstE == dstM and both are valid, valM wins (popq %rsp semantics).
  - IDs >= NREGS are silently dropped.
  - wb_en=0: no state change.
- wb_count:
  - Increments by 1 on each committing edge where at least one destination is valid.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Latency: reads 0 cycles. A write is visible on valA/valB in the cycle after the edge (without bypass).

Optional Feature:
- Macro: Y86_RF_BYPASS_EN.
- Defined: while wb_en=1, a read whose src equals a valid dstM returns valM; otherwise, if it equals a valid dstE, it returns valE. The bypass is combinational, so the same-cycle read sees the value being written.
- Undefined: reads return stored contents only. Write-edge behaviour is identical in both builds.

Decomposition:
- Package y86_pkg:
  - icode localparams (I_HALT..I_POPQ).
  - REG_NONE constant.
  - Default RSP_ID.
- Sub-module y86_src_dst_sel: purely combinational icode/cnd/rA/rB -> srcA, srcB, dstE, dstM.
- The top holds the storage array, write logic, counter, bypass and rf_flat packing.

Test Plan:
- Reset then OPq (icode=6), rA=2, rB=3 -> valA=2, valB=3, vflag=1, dstE=3, wb_count=0.
- OPq rA=2, rB=3, valE=0x55, wb_en pulse -> next cycle rf[3]=0x55, wb_count=1. Bypass build only: valB=0x55 in the same cycle.
- popq (icode=B), rA=4, valE=0x20, valM=0x99, wb_en -> rf[4]=0x99 (valM wins), wb_count+1.
- cmovxx rA=1, rB=7, cnd=0, wb_en -> rf[7] unchanged at 7, dstE=NONE, wb_count unchanged. Repeat with cnd=1 -> rf[7]=1.
- rst_n=0 asserted during wb_en=1 with valE=0xFF to rB=5 -> rf[5]=5, wb_count=0. Reset has priority.
- CNT_W=2: four valid write-backs -> wb_count sequence 1, 2, 3, 0. Unknown icode=0xC -> valA=valB=0, vflag=0.
